// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART TX state encoding and line-mux select constants.
// Revision    : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_DATA   = 2'b01;
    localparam logic [1:0] SEL_PARITY = 2'b10;
    localparam logic [1:0] SEL_STOP   = 2'b11;

    // IDLE shares the stop select so the line rests high between frames.
    function automatic logic [1:0] sel_for_state(input tx_state_t s);
        case (s)
            ST_START:  return SEL_START;
            ST_DATA:   return SEL_DATA;
            ST_PARITY: return SEL_PARITY;
            default:   return SEL_STOP;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_counter.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_counter
// Description : Bit-period timer; tick marks the final cycle of each bit.
// Revision    : 1.0
// ============================================================================
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic tick_next
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear || (r_cnt == c_CNT_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // tick_next lets the owner register a pulse that lands on the final cycle.
    assign tick      = (r_cnt == c_CNT_LAST);
    assign tick_next = (r_cnt == c_CNT_PRE);

endmodule
`default_nettype wire

// File: rtl/uart_tx_controller.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_controller
// Description : UART transmit sequencer driving an external TX line mux.
// Revision    : 1.0
// ============================================================================
module uart_tx_controller
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic [1:0] sel,
    output logic       startbit,
    output logic       databit,
    output logic       paritybit,
    output logic       stopbit,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] c_LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       c_LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic [7:0] c_DATA_MASK = 8'((1 << DATA_BITS) - 1);

    tx_state_t  r_state;
    tx_state_t  w_state_next;
    logic       w_handshake;
    logic       w_clear;
    logic       w_tick;
    logic       w_tick_next;
    logic       w_last_data;
    logic       w_last_stop;
    logic [2:0] r_bit_idx;
    logic       r_stop_idx;
    logic [7:0] r_shift;
    logic       r_parity;
    logic       r_ready;
    logic       r_busy;
    logic       r_done;
    logic [1:0] r_sel;

    assign w_handshake = tx_valid & r_ready;
    assign w_clear     = (r_state == ST_IDLE);
    assign w_last_data = w_tick && (r_bit_idx == c_LAST_BIT);
    assign w_last_stop = (r_stop_idx == c_LAST_STOP);

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_clear),
        .tick      (w_tick),
        .tick_next (w_tick_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_handshake) w_state_next = ST_START;
            ST_START:  if (w_tick) w_state_next = ST_DATA;
            ST_DATA:   if (w_last_data) w_state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_tick) w_state_next = ST_STOP;
            ST_STOP:   if (w_tick && w_last_stop) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
        end else if (w_handshake) begin
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
        end else begin
            if ((r_state == ST_DATA) && w_tick) begin
                r_bit_idx <= w_last_data ? 3'd0 : r_bit_idx + 3'd1;
            end
            if ((r_state == ST_STOP) && w_tick) begin
                r_stop_idx <= w_last_stop ? 1'b0 : 1'b1;
            end
        end
    end

    // Unused upper bits are loaded as 1s so databit idles high after a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift  <= 8'hFF;
            r_parity <= 1'b0;
        end else if (w_handshake) begin
            r_shift  <= tx_data | ~c_DATA_MASK;
            r_parity <= (^(tx_data & c_DATA_MASK)) ^ (PARITY_ODD != 0);
        end else if ((r_state == ST_DATA) && w_tick) begin
            r_shift  <= {1'b1, r_shift[7:1]};
        end
    end

    // Status outputs follow the next state so they change on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel   <= SEL_STOP;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_sel   <= sel_for_state(w_state_next);
            r_ready <= (w_state_next == ST_IDLE);
            r_busy  <= (w_state_next != ST_IDLE);
            r_done  <= (r_state == ST_STOP) && w_last_stop && w_tick_next;
        end
    end

    assign tx_ready  = r_ready;
    assign sel       = r_sel;
    assign startbit  = 1'b0;
    assign databit   = r_shift[0];
    assign paritybit = r_parity;
    assign stopbit   = 1'b1;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_controller
// Description : Four parameter variants driven in lock-step against a frame model.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_controller;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] sel_v;
    logic [3:0] ready_v, start_v, data_v, par_v, stop_v, busy_v, done_v;

    int checks = 0;
    int errors = 0;

    // Variant 0: even/1 stop, 1: odd parity, 2: no parity, 3: two stop bits
    int PEN [4] = '{1, 1, 0, 1};
    int ODD [4] = '{0, 1, 0, 0};
    int STP [4] = '{1, 1, 1, 2};

    for (genvar k = 0; k < 4; k++) begin : g_dut
        uart_tx_controller #(
            .CLKS_PER_BIT (CPB),
            .DATA_BITS    (8),
            .PARITY_EN    ((k == 2) ? 0 : 1),
            .PARITY_ODD   ((k == 1) ? 1 : 0),
            .STOP_BITS    ((k == 3) ? 2 : 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .tx_valid  (tx_valid),
            .tx_data   (tx_data),
            .tx_ready  (ready_v[k]),
            .sel       (sel_v[2*k +: 2]),
            .startbit  (start_v[k]),
            .databit   (data_v[k]),
            .paritybit (par_v[k]),
            .stopbit   (stop_v[k]),
            .busy      (busy_v[k]),
            .done      (done_v[k])
        );
    end

    always #5 clk = ~clk;

    function automatic int frame_len(input int k);
        return (1 + 8 + PEN[k] + STP[k]) * CPB;
    endfunction

    function automatic logic exp_line(input logic [7:0] d, input int k, input int cyc);
        int b;
        b = (cyc - 1) / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if ((PEN[k] == 1) && (b == 9)) return (^d) ^ (ODD[k] != 0);
        return 1'b1;
    endfunction

    function automatic logic line_of(input int k);
        case (sel_v[2*k +: 2])
            2'b00:   return start_v[k];
            2'b01:   return data_v[k];
            2'b10:   return par_v[k];
            default: return stop_v[k];
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_frame(input logic [7:0] d);
        @(negedge clk);
        checks++;
        if (ready_v !== 4'hF) begin
            errors++;
            $display("FAIL ready_before_send: got %b expected 1111", ready_v);
        end
        tx_valid = 1'b1;
        tx_data  = d;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    // Checks cycle i after the handshake edge against the frame model.
    task automatic run_frames(input logic [7:0] d, input logic [3:0] mask, input int extra);
        int lim;
        lim = 0;
        for (int k = 0; k < 4; k++)
            if (mask[k] && (frame_len(k) + 1 > lim)) lim = frame_len(k) + 1;
        lim += extra;
        for (int i = 1; i <= lim; i++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (mask[k]) begin
                    if (i <= frame_len(k)) begin
                        checks++;
                        if (line_of(k) !== exp_line(d, k, i)) begin
                            errors++;
                            $display("FAIL line dut%0d data=%02h cycle=%0d: got %b expected %b",
                                     k, d, i, line_of(k), exp_line(d, k, i));
                        end
                        checks++;
                        if ({busy_v[k], ready_v[k], done_v[k]} !== {2'b10, (i == frame_len(k))}) begin
                            errors++;
                            $display("FAIL status dut%0d data=%02h cycle=%0d: busy/ready/done got %b%b%b expected 10%b",
                                     k, d, i, busy_v[k], ready_v[k], done_v[k], (i == frame_len(k)));
                        end
                    end else begin
                        checks++;
                        if ({busy_v[k], ready_v[k], done_v[k], sel_v[2*k +: 2]} !== 5'b01011) begin
                            errors++;
                            $display("FAIL idle dut%0d cycle=%0d: busy/ready/done/sel got %b%b%b%b expected 01011",
                                     k, i, busy_v[k], ready_v[k], done_v[k], sel_v[2*k +: 2]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic send(input logic [7:0] d);
        start_frame(d);
        run_frames(d, 4'hF, 2);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({sel_v, start_v, data_v, par_v, stop_v, busy_v, done_v} !==
            {8'hFF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset_values: sel=%b start=%b data=%b par=%b stop=%b busy=%b done=%b expected FF/0/F/0/F/0/0",
                     sel_v, start_v, data_v, par_v, stop_v, busy_v, done_v);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_v !== 4'hF) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1111", ready_v);
        end
    endtask

    task automatic test_a5();
        logic [10:0] seq;
        seq = 11'b10101001010;
        do_reset();
        start_frame(8'hA5);
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (i <= 44) begin
                checks++;
                if ((line_of(0) !== seq[(i-1)/CPB]) || (done_v[0] !== (i == 44))) begin
                    errors++;
                    $display("FAIL a5_frame cycle=%0d: line/done got %b%b expected %b%b",
                             i, line_of(0), done_v[0], seq[(i-1)/CPB], (i == 44));
                end
            end else begin
                checks++;
                if ({ready_v[0], done_v[0]} !== 2'b10) begin
                    errors++;
                    $display("FAIL a5_ready cycle=45: ready/done got %b%b expected 10", ready_v[0], done_v[0]);
                end
            end
        end
    endtask

    task automatic test_parity_modes();
        do_reset();
        send(8'h07);
    endtask

    task automatic test_stop2();
        do_reset();
        send(8'h00);
    endtask

    task automatic test_random();
        do_reset();
        repeat (12) send(8'($urandom));
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h11;
        @(posedge clk);
        #1 tx_data = 8'h22;
        run_frames(8'h11, 4'b0001, 0);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        tx_data = 8'($urandom);
        run_frames(8'h22, 4'b0001, 2);
    endtask

    task automatic test_ignore_busy();
        logic [7:0] d;
        d = 8'($urandom);
        do_reset();
        start_frame(d);
        fork
            run_frames(d, 4'hF, 3);
            begin
                repeat (14) @(posedge clk);
                #1 tx_valid = 1'b1;
                tx_data = ~d;
                @(posedge clk);
                #1 tx_valid = 1'b0;
                tx_data = 8'($urandom);
            end
        join
    endtask

    task automatic test_reset_abort();
        do_reset();
        start_frame(8'h5A);
        repeat (13) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sel_v, busy_v, done_v} !== {8'hFF, 4'h0, 4'h0}) begin
            errors++;
            $display("FAIL async_abort: sel=%b busy=%b done=%b expected 11111111/0000/0000", sel_v, busy_v, done_v);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({sel_v, busy_v, done_v} !== {8'hFF, 4'h0, 4'h0}) begin
                errors++;
                $display("FAIL abort_hold: sel=%b busy=%b done=%b expected 11111111/0000/0000", sel_v, busy_v, done_v);
            end
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({busy_v, done_v, ready_v} !== 12'h00F) begin
                errors++;
                $display("FAIL abort_release: busy=%b done=%b ready=%b expected 0000/0000/1111", busy_v, done_v, ready_v);
            end
        end
        send(8'hFF);
    endtask

    initial begin
        test_reset();
        test_a5();
        test_parity_modes();
        test_stop2();
        test_back_to_back();
        test_ignore_busy();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
